mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// Shares one single-ported backing memory (BRAM now, DDR3 controller front-end later) between the
// instruction-fetch port and the data (load/store) port of the 5-stage pipeline. It serializes one
// transaction at a time, runs the memory-side req/ready/rvalid handshake, and raises per-port stall
// flags so the pipeline freezes until the port's transaction completes.
// PARAMETERS
// DATA_WIDTH    32  data word width; byte-enable width is DATA_WIDTH/8
// ADDR_WIDTH    32  byte address width on every port
// STARVE_LIMIT  4   consecutive data grants allowed while fetch waits (guard build only)
// PORTS
// i_clk         in   1      clock, all state on rising edge
// i_reset_n     in   1      asynchronous, active-low reset
// i_if_req      in   1      fetch read request; held with i_if_addr until o_if_rvalid
// i_if_addr     in   ADDR   fetch address
// o_if_gnt      out  1      1-cycle pulse: fetch request captured
// o_if_rvalid   out  1      1-cycle pulse: fetch data valid (completion)
// o_if_rdata    out  DATA   fetch read data, valid with o_if_rvalid
// i_dm_req      in   1      data request; held with addr/we/wdata/be until o_dm_rvalid
// i_dm_we       in   1      1 = store, 0 = load
// i_dm_addr     in   ADDR   data address
// i_dm_wdata    in   DATA   store data
// i_dm_be       in   DATA/8 store byte enables
// o_dm_gnt      out  1      1-cycle pulse: data request captured
// o_dm_rvalid   out  1      1-cycle pulse: load data valid or store acknowledged
// o_dm_rdata    out  DATA   load data, valid with o_dm_rvalid
// o_mem_req     out  1      memory request, held until i_mem_ready
// o_mem_we/addr/wdata/be  out  1/ADDR/DATA/DATA/8  captured transaction fields, stable while o_mem_req
// i_mem_ready   in   1      memory accepts request this cycle
// i_mem_rvalid  in   1      memory read data valid
// i_mem_rdata   in   DATA   memory read data
// o_stall_if    out  1      i_if_req & ~o_if_rvalid
// o_stall_mem   out  1      i_dm_req & ~o_dm_rvalid
// BEHAVIOUR
// - FSM in package enum: IDLE -> ISSUE -> RESP -> IDLE. Owner register {FETCH, DATA} set on capture.
// - IDLE: if any req, capture winner's fields into registers, pulse its gnt, go ISSUE. Data port wins
//   ties (older instruction). Capture only in IDLE; loser stays pending.
// - ISSUE: o_mem_req=1 with registered fields. On i_mem_ready: store -> o_dm_rvalid pulse same cycle,
//   go IDLE; load/fetch -> go RESP.
// - RESP: on i_mem_rvalid, owner's rvalid=1 and rdata=i_mem_rdata (combinational pass), go IDLE.
// - Min read latency: req at cycle 0, gnt cycle 0, mem_req cycle 1 (ready), rvalid cycle 2 if memory
//   returns next cycle. Store with immediate ready completes cycle 1. Next capture earliest cycle after
//   completion.
// - i_mem_rvalid in IDLE/ISSUE is ignored (no port pulse). Requester dropping req mid-transaction does
//   not abort; transaction completes and completion pulse is still issued.
// - Non-owner rvalid/rdata = 0. Stall flags combinational from held req.
// - Reset (async, any state): state=IDLE, owner=FETCH, captured regs=0, starve ctr=0; all outputs 0
//   (o_*_rdata=0, o_mem_req=0 immediately). Late memory response after reset is ignored.
// CONFIGURATION
// MEM_ARB_STARVE_GUARD_EN defined: counter increments per data grant made while i_if_req=1, clears on
// fetch grant; when count==STARVE_LIMIT fetch wins the next tie. Undefined: strict data priority,
// no counter, STARVE_LIMIT unused.
// STRUCTURE
// mem_arb_pkg: arb_state_t (IDLE/ISSUE/RESP), arb_owner_t (FETCH/DATA), BE_WIDTH function.
// Sub-module mem_arb_starve_ctr (counter + limit compare), instantiated only under the macro.
// TESTING
// 1 fetch read 0x10, mem ready=1, rvalid next cycle data 0xDEADBEEF -> if_gnt c0, mem_req c1, if_rvalid c2 with 0xDEADBEEF.
// 2 simultaneous if_req 0x20 + dm load 0x40 -> dm granted first; fetch granted cycle after dm_rvalid; stall_if high throughout.
// 3 store addr 0x80 wdata 0x12345678 be 4'b0011, ready held low 3 cycles -> mem fields stable, dm_rvalid on ready cycle.
// 4 guard build, STARVE_LIMIT=4, dm_req held for 6 back-to-back loads with if_req=1 -> fetch wins after 4th data completion.
// 5 assert i_reset_n=0 in RESP, then mem rvalid after release -> all outputs 0 asynchronously, no rvalid to any port.
// 6 spurious i_mem_rvalid in IDLE, and in ISSUE before ready -> no port completion pulse, FSM state unchanged.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states, transaction owner
// and the byte-enable width helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } arb_owner_t;

  // One enable bit per byte of the data word.
  function automatic int BE_WIDTH(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Fetch starvation guard: counts data grants made while fetch is waiting and
// flags when fetch must win the next tie. Only instantiated when
// MEM_ARB_STARVE_GUARD_EN is defined.
module mem_arb_starve_ctr #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_data_grant,   // data grant made while fetch request is pending
  input  logic i_fetch_grant,  // fetch grant made this cycle
  output logic o_fetch_first
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] count;

  // Saturating count of data grants that overtook a waiting fetch.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count <= '0;
    end else if (i_fetch_grant) begin
      count <= '0;
    end else if (i_data_grant && (count != CW'(STARVE_LIMIT))) begin
      count <= count + CW'(1);
    end
  end

  assign o_fetch_first = (count == CW'(STARVE_LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the instruction-fetch port and the
// load/store port. One transaction at a time: capture in IDLE, hold the
// memory request in ISSUE until accepted, wait for read data in RESP.
// Data port wins ties; defining MEM_ARB_STARVE_GUARD_EN lets fetch win a tie
// after STARVE_LIMIT consecutive data grants that overtook it.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                            i_clk,
  input  logic                            i_reset_n,
  // instruction-fetch port (read only)
  input  logic                            i_if_req,
  input  logic [ADDR_WIDTH-1:0]           i_if_addr,
  output logic                            o_if_gnt,
  output logic                            o_if_rvalid,
  output logic [DATA_WIDTH-1:0]           o_if_rdata,
  // data port (load/store)
  input  logic                            i_dm_req,
  input  logic                            i_dm_we,
  input  logic [ADDR_WIDTH-1:0]           i_dm_addr,
  input  logic [DATA_WIDTH-1:0]           i_dm_wdata,
  input  logic [BE_WIDTH(DATA_WIDTH)-1:0] i_dm_be,
  output logic                            o_dm_gnt,
  output logic                            o_dm_rvalid,
  output logic [DATA_WIDTH-1:0]           o_dm_rdata,
  // backing memory
  output logic                            o_mem_req,
  output logic                            o_mem_we,
  output logic [ADDR_WIDTH-1:0]           o_mem_addr,
  output logic [DATA_WIDTH-1:0]           o_mem_wdata,
  output logic [BE_WIDTH(DATA_WIDTH)-1:0] o_mem_be,
  input  logic                            i_mem_ready,
  input  logic                            i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0]           i_mem_rdata,
  // pipeline freeze
  output logic                            o_stall_if,
  output logic                            o_stall_mem
);

  localparam int BEW = BE_WIDTH(DATA_WIDTH);

  arb_state_t            state;
  arb_owner_t            owner;
  logic                  cap_we;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic [BEW-1:0]        cap_be;

  logic grant_fetch;
  logic grant_data;
  logic fetch_first;
  logic store_done;
  logic read_done;

`ifdef MEM_ARB_STARVE_GUARD_EN
  mem_arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_data_grant  (grant_data & i_if_req),
    .i_fetch_grant (grant_fetch),
    .o_fetch_first (fetch_first)
  );
`else
  // Strict data priority: fetch never wins a tie.
  assign fetch_first = 1'b0;
`endif

  // Pick the winner among pending requests; grants only exist in IDLE.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    grant_fetch = 1'b0;
    grant_data  = 1'b0;
    if ((state == IDLE) && i_reset_n) begin
      if (i_dm_req && !(i_if_req && fetch_first)) begin
        grant_data = 1'b1;
      end else if (i_if_req) begin
        grant_fetch = 1'b1;
      end
    end
  end

  // Transaction FSM plus capture of the winning request's fields.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!i_reset_n) begin
      state     <= IDLE;
      owner     <= FETCH;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_be    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_data) begin
            owner     <= DATA;
            cap_we    <= i_dm_we;
            cap_addr  <= i_dm_addr;
            cap_wdata <= i_dm_wdata;
            cap_be    <= i_dm_be;
            state     <= ISSUE;
          end else if (grant_fetch) begin
            owner     <= FETCH;
            cap_we    <= 1'b0;
            cap_addr  <= i_if_addr;
            cap_wdata <= '0;
            cap_be    <= '0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (i_mem_ready) begin
            state <= cap_we ? IDLE : RESP;
          end
        end
        RESP: begin
          if (i_mem_rvalid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stores finish on acceptance; reads finish on returned data in RESP only,
  // so stray memory responses in IDLE/ISSUE never reach a port.
  assign store_done = (state == ISSUE) && i_mem_ready && cap_we;
  assign read_done  = (state == RESP) && i_mem_rvalid;

  assign o_if_gnt    = grant_fetch;
  assign o_dm_gnt    = grant_data;

  assign o_if_rvalid = read_done && (owner == FETCH);
  assign o_dm_rvalid = store_done || (read_done && (owner == DATA));
  assign o_if_rdata  = (read_done && (owner == FETCH)) ? i_mem_rdata : '0;
  assign o_dm_rdata  = (read_done && (owner == DATA))  ? i_mem_rdata : '0;

  assign o_mem_req   = (state == ISSUE);
  assign o_mem_we    = cap_we;
  assign o_mem_addr  = cap_addr;
  assign o_mem_wdata = cap_wdata;
  assign o_mem_be    = cap_be;

  // Stalls follow the held requests, forced low while in reset.
  assign o_stall_if  = i_reset_n && i_if_req && !o_if_rvalid;
  assign o_stall_mem = i_reset_n && i_dm_req && !o_dm_rvalid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by a
// randomized run against a transaction-level model of the arbiter and memory.
// Define MEM_ARB_STARVE_GUARD_EN for both bench and RTL to cover the guard.
module tb_mem_port_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int LIMIT = 4;

  logic          i_clk;
  logic          i_reset_n;
  logic          i_if_req;
  logic [AW-1:0] i_if_addr;
  logic          o_if_gnt;
  logic          o_if_rvalid;
  logic [DW-1:0] o_if_rdata;
  logic          i_dm_req;
  logic          i_dm_we;
  logic [AW-1:0] i_dm_addr;
  logic [DW-1:0] i_dm_wdata;
  logic [3:0]    i_dm_be;
  logic          o_dm_gnt;
  logic          o_dm_rvalid;
  logic [DW-1:0] o_dm_rdata;
  logic          o_mem_req;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic [3:0]    o_mem_be;
  logic          i_mem_ready;
  logic          i_mem_rvalid;
  logic [DW-1:0] i_mem_rdata;
  logic          o_stall_if;
  logic          o_stall_mem;

  mem_port_arbiter #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_if_req     (i_if_req),
    .i_if_addr    (i_if_addr),
    .o_if_gnt     (o_if_gnt),
    .o_if_rvalid  (o_if_rvalid),
    .o_if_rdata   (o_if_rdata),
    .i_dm_req     (i_dm_req),
    .i_dm_we      (i_dm_we),
    .i_dm_addr    (i_dm_addr),
    .i_dm_wdata   (i_dm_wdata),
    .i_dm_be      (i_dm_be),
    .o_dm_gnt     (o_dm_gnt),
    .o_dm_rvalid  (o_dm_rvalid),
    .o_dm_rdata   (o_dm_rdata),
    .o_mem_req    (o_mem_req),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_be     (o_mem_be),
    .i_mem_ready  (i_mem_ready),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata),
    .o_stall_if   (o_stall_if),
    .o_stall_mem  (o_stall_mem)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Transaction-level model state for the randomized phase.
  logic [31:0] mem_model [16];
  logic        m_busy, m_port, m_we, m_acc;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  int          m_wait;
  int          starve_cnt;
  logic        if_done, dm_done;
  logic        exp_ig, exp_dg, exp_mreq, store_done, read_done, exp_irv, exp_drv, pref;
  logic [31:0] exp_ird, exp_drd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic mid();
    @(negedge i_clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_if_gnt"},    o_if_gnt,    0);
    check({tag, "_dm_gnt"},    o_dm_gnt,    0);
    check({tag, "_if_rvalid"}, o_if_rvalid, 0);
    check({tag, "_dm_rvalid"}, o_dm_rvalid, 0);
    check({tag, "_if_rdata"},  o_if_rdata,  0);
    check({tag, "_dm_rdata"},  o_dm_rdata,  0);
    check({tag, "_mem_req"},   o_mem_req,   0);
    check({tag, "_mem_we"},    o_mem_we,    0);
    check({tag, "_mem_addr"},  o_mem_addr,  0);
    check({tag, "_mem_wdata"}, o_mem_wdata, 0);
    check({tag, "_mem_be"},    o_mem_be,    0);
    check({tag, "_stall_if"},  o_stall_if,  0);
    check({tag, "_stall_mem"}, o_stall_mem, 0);
  endtask

  initial begin
    i_reset_n = 1'b0; i_if_req = 1'b1; i_if_addr = '0;
    i_dm_req = 1'b1; i_dm_we = 1'b0; i_dm_addr = '0; i_dm_wdata = '0; i_dm_be = '0;
    i_mem_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;

    // Reset state, with both requests held high.
    #3;
    check_all_zero("rst");
    #10;
    tick();
    i_if_req = 1'b0; i_dm_req = 1'b0; i_reset_n = 1'b1;

    // Fetch read, immediate ready, data one cycle later.
    tick();
    i_if_req = 1'b1; i_if_addr = 32'h10; i_mem_ready = 1'b1;
    mid();
    check("t1_if_gnt", o_if_gnt, 1);
    check("t1_dm_gnt", o_dm_gnt, 0);
    check("t1_mem_req_c0", o_mem_req, 0);
    check("t1_stall_if_c0", o_stall_if, 1);
    tick();
    mid();
    check("t1_mem_req_c1", o_mem_req, 1);
    check("t1_mem_addr", o_mem_addr, 32'h10);
    check("t1_mem_we", o_mem_we, 0);
    check("t1_if_rvalid_c1", o_if_rvalid, 0);
    tick();
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'hDEADBEEF;
    mid();
    check("t1_if_rvalid_c2", o_if_rvalid, 1);
    check("t1_if_rdata", o_if_rdata, 32'hDEADBEEF);
    check("t1_stall_if_c2", o_stall_if, 0);
    check("t1_dm_rvalid", o_dm_rvalid, 0);
    check("t1_dm_rdata", o_dm_rdata, 0);
    tick();
    i_if_req = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
    mid();
    check("t1_idle_mem_req", o_mem_req, 0);
    check("t1_idle_if_gnt", o_if_gnt, 0);

    // Simultaneous fetch and load: data first, then fetch.
    tick();
    i_if_req = 1'b1; i_if_addr = 32'h20;
    i_dm_req = 1'b1; i_dm_we = 1'b0; i_dm_addr = 32'h40;
    mid();
    check("t2_dm_gnt", o_dm_gnt, 1);
    check("t2_if_gnt_tie", o_if_gnt, 0);
    check("t2_stall_if_a", o_stall_if, 1);
    check("t2_stall_mem_a", o_stall_mem, 1);
    tick();
    mid();
    check("t2_mem_addr_dm", o_mem_addr, 32'h40);
    check("t2_if_gnt_busy", o_if_gnt, 0);
    check("t2_stall_if_b", o_stall_if, 1);
    tick();
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'hCAFE0040;
    mid();
    check("t2_dm_rvalid", o_dm_rvalid, 1);
    check("t2_dm_rdata", o_dm_rdata, 32'hCAFE0040);
    check("t2_if_rvalid_no", o_if_rvalid, 0);
    check("t2_if_rdata_zero", o_if_rdata, 0);
    check("t2_stall_if_c", o_stall_if, 1);
    check("t2_stall_mem_c", o_stall_mem, 0);
    tick();
    i_dm_req = 1'b0; i_mem_rvalid = 1'b0;
    mid();
    check("t2_if_gnt", o_if_gnt, 1);
    check("t2_stall_if_d", o_stall_if, 1);
    tick();
    mid();
    check("t2_mem_addr_if", o_mem_addr, 32'h20);
    tick();
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'h0BADF00D;
    mid();
    check("t2_if_rvalid", o_if_rvalid, 1);
    check("t2_if_rdata", o_if_rdata, 32'h0BADF00D);
    tick();
    i_if_req = 1'b0; i_mem_rvalid = 1'b0;

    // Store with memory stalling three cycles.
    tick();
    i_dm_req = 1'b1; i_dm_we = 1'b1; i_dm_addr = 32'h80;
    i_dm_wdata = 32'h12345678; i_dm_be = 4'b0011; i_mem_ready = 1'b0;
    mid();
    check("t3_dm_gnt", o_dm_gnt, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      mid();
      check("t3_mem_req_hold", o_mem_req, 1);
      check("t3_mem_we", o_mem_we, 1);
      check("t3_mem_addr", o_mem_addr, 32'h80);
      check("t3_mem_wdata", o_mem_wdata, 32'h12345678);
      check("t3_mem_be", o_mem_be, 4'b0011);
      check("t3_dm_rvalid_wait", o_dm_rvalid, 0);
      check("t3_stall_mem", o_stall_mem, 1);
    end
    tick();
    i_mem_ready = 1'b1;
    mid();
    check("t3_mem_req_acc", o_mem_req, 1);
    check("t3_dm_rvalid", o_dm_rvalid, 1);
    check("t3_dm_rdata", o_dm_rdata, 0);
    check("t3_stall_mem_done", o_stall_mem, 0);
    tick();
    i_dm_req = 1'b0; i_dm_we = 1'b0; i_mem_ready = 1'b0;
    mid();
    check("t3_mem_req_idle", o_mem_req, 0);
    check("t3_dm_rvalid_idle", o_dm_rvalid, 0);

    // Spurious memory rvalid in IDLE and in ISSUE before ready.
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'hFFFFFFFF;
    tick();
    mid();
    check("t6_idle_if_rvalid", o_if_rvalid, 0);
    check("t6_idle_dm_rvalid", o_dm_rvalid, 0);
    check("t6_idle_mem_req", o_mem_req, 0);
    tick();
    i_mem_rvalid = 1'b0; i_if_req = 1'b1; i_if_addr = 32'h30;
    mid();
    check("t6_if_gnt", o_if_gnt, 1);
    tick();
    i_mem_rvalid = 1'b1;
    mid();
    check("t6_issue_if_rvalid", o_if_rvalid, 0);
    check("t6_issue_if_rdata", o_if_rdata, 0);
    check("t6_issue_mem_req", o_mem_req, 1);
    tick();
    i_mem_rvalid = 1'b0;
    mid();
    check("t6_still_issue", o_mem_req, 1);
    tick();
    i_mem_ready = 1'b1;
    mid();
    check("t6_accept", o_mem_req, 1);
    tick();
    i_mem_ready = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h5A5A5A5A;
    mid();
    check("t6_if_rvalid", o_if_rvalid, 1);
    check("t6_if_rdata", o_if_rdata, 32'h5A5A5A5A);
    tick();
    i_if_req = 1'b0; i_mem_rvalid = 1'b0;

`ifdef MEM_ARB_STARVE_GUARD_EN
    // Six back-to-back loads with fetch waiting: fetch wins after the fourth.
    tick();
    i_if_req = 1'b1; i_if_addr = 32'h100;
    i_dm_req = 1'b1; i_dm_we = 1'b0; i_dm_addr = 32'h200; i_mem_ready = 1'b1;
    for (int n = 0; n < 7; n++) begin
      mid();
      check("t4_dm_gnt", o_dm_gnt, (n == 4) ? 1'b0 : 1'b1);
      check("t4_if_gnt", o_if_gnt, (n == 4) ? 1'b1 : 1'b0);
      tick();
      mid();
      check("t4_mem_addr", o_mem_addr, (n == 4) ? 32'h100 : 32'h200);
      tick();
      i_mem_rvalid = 1'b1; i_mem_rdata = 32'hA0000000 + 32'(n);
      mid();
      check("t4_if_rvalid", o_if_rvalid, (n == 4) ? 1'b1 : 1'b0);
      check("t4_dm_rvalid", o_dm_rvalid, (n == 4) ? 1'b0 : 1'b1);
      tick();
      i_mem_rvalid = 1'b0;
      if (n == 6) begin
        i_if_req = 1'b0; i_dm_req = 1'b0;
      end
    end
`endif

    // Reset asserted while waiting for read data; late response is dropped.
    tick();
    i_if_req = 1'b1; i_if_addr = 32'h44; i_mem_ready = 1'b1;
    mid();
    check("t5_if_gnt", o_if_gnt, 1);
    tick();
    mid();
    check("t5_mem_req", o_mem_req, 1);
    tick();
    i_mem_ready = 1'b0;
    #2;
    i_reset_n = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h77777777;
    #1;
    check_all_zero("t5_async");
    i_if_req = 1'b0;
    tick();
    tick();
    i_reset_n = 1'b1;
    mid();
    check("t5_late_if_rvalid", o_if_rvalid, 0);
    check("t5_late_dm_rvalid", o_dm_rvalid, 0);
    check("t5_late_if_rdata", o_if_rdata, 0);
    check("t5_late_mem_req", o_mem_req, 0);
    tick();
    i_mem_rvalid = 1'b0;
    mid();
    check("t5_idle_mem_req", o_mem_req, 0);

    // Randomized traffic against a transaction-level model.
    for (int i = 0; i < 16; i++) mem_model[i] = $urandom;
    m_busy = 0; m_port = 0; m_we = 0; m_acc = 0; m_addr = '0; m_wdata = '0; m_be = '0;
    m_wait = 0; starve_cnt = 0; if_done = 0; dm_done = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      tick();
      if (if_done) begin if_done = 0; i_if_req = 1'b0; end
      if (dm_done) begin dm_done = 0; i_dm_req = 1'b0; end
      if (!i_if_req && ($urandom_range(0, 2) == 0)) begin
        i_if_req  = 1'b1;
        i_if_addr = 32'($urandom_range(0, 15)) << 2;
      end
      if (!i_dm_req && ($urandom_range(0, 2) == 0)) begin
        i_dm_req   = 1'b1;
        i_dm_we    = 1'($urandom_range(0, 1));
        i_dm_addr  = 32'($urandom_range(0, 15)) << 2;
        i_dm_wdata = $urandom;
        i_dm_be    = 4'($urandom_range(1, 15));
      end
      i_mem_ready = 1'($urandom_range(0, 1));
      if (m_acc) begin
        if (m_wait == 0) begin
          i_mem_rvalid = 1'b1;
          i_mem_rdata  = mem_model[m_addr[5:2]];
        end else begin
          i_mem_rvalid = 1'b0;
          m_wait--;
        end
      end else begin
        i_mem_rvalid = ($urandom_range(0, 7) == 0);
        i_mem_rdata  = $urandom;
      end
      mid();
`ifdef MEM_ARB_STARVE_GUARD_EN
      pref = (starve_cnt == LIMIT);
`else
      pref = 1'b0;
`endif
      exp_ig = 0; exp_dg = 0;
      if (!m_busy) begin
        if (i_dm_req && !(i_if_req && pref)) exp_dg = 1;
        else if (i_if_req) exp_ig = 1;
      end
      exp_mreq   = m_busy && !m_acc;
      store_done = exp_mreq && i_mem_ready && m_we;
      read_done  = m_acc && i_mem_rvalid;
      exp_irv    = read_done && (m_port == 0);
      exp_drv    = store_done || (read_done && (m_port == 1));
      exp_ird    = exp_irv ? mem_model[i_if_addr[5:2]] : 32'h0;
      exp_drd    = (read_done && (m_port == 1)) ? mem_model[i_dm_addr[5:2]] : 32'h0;
      check("rnd_if_gnt", o_if_gnt, exp_ig);
      check("rnd_dm_gnt", o_dm_gnt, exp_dg);
      check("rnd_mem_req", o_mem_req, exp_mreq);
      if (exp_mreq) begin
        check("rnd_mem_we", o_mem_we, m_we);
        check("rnd_mem_addr", o_mem_addr, m_addr);
        check("rnd_mem_wdata", o_mem_wdata, m_wdata);
        check("rnd_mem_be", o_mem_be, m_be);
      end
      check("rnd_if_rvalid", o_if_rvalid, exp_irv);
      check("rnd_dm_rvalid", o_dm_rvalid, exp_drv);
      check("rnd_if_rdata", o_if_rdata, exp_ird);
      check("rnd_dm_rdata", o_dm_rdata, exp_drd);
      check("rnd_stall_if", o_stall_if, i_if_req && !exp_irv);
      check("rnd_stall_mem", o_stall_mem, i_dm_req && !exp_drv);
      if (exp_dg) begin
        m_busy = 1; m_port = 1; m_we = i_dm_we; m_addr = i_dm_addr;
        m_wdata = i_dm_wdata; m_be = i_dm_be; m_acc = 0;
        if (i_if_req && (starve_cnt < LIMIT)) starve_cnt++;
      end else if (exp_ig) begin
        m_busy = 1; m_port = 0; m_we = 0; m_addr = i_if_addr;
        m_wdata = '0; m_be = '0; m_acc = 0;
        starve_cnt = 0;
      end else if (store_done) begin
        for (int b = 0; b < 4; b++)
          if (m_be[b]) mem_model[m_addr[5:2]][8*b +: 8] = m_wdata[8*b +: 8];
        m_busy = 0;
        dm_done = 1;
      end else if (exp_mreq && i_mem_ready) begin
        m_acc  = 1;
        m_wait = $urandom_range(0, 2);
      end else if (read_done) begin
        m_busy = 0; m_acc = 0;
        if (m_port) dm_done = 1;
        else if_done = 1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
